// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one synchronous single-port ROM/RAM between a ROM download stream
// (writes) and two read requesters (main CPU and sound CPU).
//
// Handshakes:
//   - Reads: cpu_req/snd_req are levels held with a stable address. The
//     read is complete when the matching *_ack pulses for one cycle; *_rdata
//     is valid in that cycle and held until the next ack to that requester.
//     A requester whose ack is high is not arbitrated in that cycle, so a
//     requester may drop or re-raise its req in the cycle after its ack.
//   - Download: dl_wr is a one-cycle strobe. dl_wait is high while the
//     one-entry write buffer is full. A strobe that lands while the buffer is
//     full (and not being freed that cycle) is dropped and latches the sticky
//     dl_overflow flag.
//
// Ports:
//   clk_sys, reset_n             clock, asynchronous active-low reset
//   dl_wr, dl_addr, dl_data      download write strobe/address/data
//   dl_wait, dl_overflow         buffer-full back-pressure, sticky drop flag
//   cpu_req/addr, cpu_ack/rdata  main CPU read port
//   snd_req/addr, snd_ack/rdata  sound CPU read port
//   mem_addr, mem_we, mem_d      registered command to the memory
//   mem_q                        memory read data (one cycle after address)
//   dbg_state                    current FSM state (IDLE=0, RD_ISSUE=1,
//                                RD_WAIT=2, WR_ISSUE=3)
//
// Configuration:
//   MEM_ARB_STARVE_GUARD_EN  when defined, after 4 consecutive write grants
//                            with a read pending, the next arbitration grants
//                            the read. When undefined, writes always win.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW = 16,
    parameter int DW = 8
) (
    input  logic          clk_sys,
    input  logic          reset_n,

    input  logic          dl_wr,
    input  logic [AW-1:0] dl_addr,
    input  logic [DW-1:0] dl_data,
    output logic          dl_wait,
    output logic          dl_overflow,

    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,

    input  logic          snd_req,
    input  logic [AW-1:0] snd_addr,
    output logic          snd_ack,
    output logic [DW-1:0] snd_rdata,

    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_d,
    input  logic [DW-1:0] mem_q,

    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_ISSUE = 2'd1,
        ST_RD_WAIT  = 2'd2,
        ST_WR_ISSUE = 2'd3
    } state_t;

    state_t        state_q,      state_d;
    logic          buf_full_q,   buf_full_d;
    logic [AW-1:0] buf_addr_q,   buf_addr_d;
    logic [DW-1:0] buf_data_q,   buf_data_d;
    logic          overflow_q,   overflow_d;
    logic          last_snd_q,   last_snd_d;   // 1: last read grant went to snd
    logic          rd_snd_q,     rd_snd_d;     // 1: read in flight is for snd
    logic          cpu_ack_q,    cpu_ack_d;
    logic          snd_ack_q,    snd_ack_d;
    logic [DW-1:0] cpu_rdata_q,  cpu_rdata_d;
    logic [DW-1:0] snd_rdata_q,  snd_rdata_d;
    logic [AW-1:0] mem_addr_q,   mem_addr_d;
    logic          mem_we_q,     mem_we_d;
    logic [DW-1:0] mem_d_q,      mem_d_d;

    logic cpu_pend;
    logic snd_pend;
    logic rd_pend;
    logic pick_snd;
    logic guard_trip;
    logic wr_grant;
    logic rd_grant;
    logic buf_free;
    logic dl_accept;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam logic [2:0] STARVE_LIMIT = 3'd4;
    logic [2:0] starve_cnt_q, starve_cnt_d;
`endif

    // Requesters acked this cycle are masked so a held req is not re-served
    // before the requester has seen its data.
    assign cpu_pend = cpu_req & ~cpu_ack_q;
    assign snd_pend = snd_req & ~snd_ack_q;
    assign rd_pend  = cpu_pend | snd_pend;

    // Round-robin: on a tie, serve whoever did not get the last read.
    assign pick_snd = snd_pend & (~cpu_pend | ~last_snd_q);

`ifdef MEM_ARB_STARVE_GUARD_EN
    assign guard_trip = (starve_cnt_q == STARVE_LIMIT) & rd_pend;
`else
    assign guard_trip = 1'b0;
`endif

    assign wr_grant = (state_q == ST_IDLE) & buf_full_q & ~guard_trip;
    assign rd_grant = (state_q == ST_IDLE) & rd_pend & ~wr_grant;

    // The buffer entry is consumed by the WR_ISSUE cycle, so a strobe in that
    // cycle can refill it; this keeps back-to-back writes at one per 2 cycles.
    assign buf_free  = (state_q == ST_WR_ISSUE);
    assign dl_accept = dl_wr & (~buf_full_q | buf_free);

    always_comb begin
        state_d     = state_q;
        buf_full_d  = buf_full_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        overflow_d  = overflow_q;
        last_snd_d  = last_snd_q;
        rd_snd_d    = rd_snd_q;
        cpu_ack_d   = 1'b0;
        snd_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        snd_rdata_d = snd_rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_d_d     = mem_d_q;
`ifdef MEM_ARB_STARVE_GUARD_EN
        starve_cnt_d = starve_cnt_q;
`endif

        // Write buffer
        if (dl_accept) begin
            buf_full_d = 1'b1;
            buf_addr_d = dl_addr;
            buf_data_d = dl_data;
        end else if (buf_free) begin
            buf_full_d = 1'b0;
        end
        if (dl_wr && !dl_accept) begin
            overflow_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (wr_grant) begin
                    state_d    = ST_WR_ISSUE;
                    mem_we_d   = 1'b1;
                    mem_addr_d = buf_addr_q;
                    mem_d_d    = buf_data_q;
                end else if (rd_grant) begin
                    state_d    = ST_RD_ISSUE;
                    mem_addr_d = pick_snd ? snd_addr : cpu_addr;
                    rd_snd_d   = pick_snd;
                    last_snd_d = pick_snd;
                end
`ifdef MEM_ARB_STARVE_GUARD_EN
                if (rd_grant) begin
                    starve_cnt_d = '0;
                end else if (wr_grant && rd_pend) begin
                    if (starve_cnt_q != STARVE_LIMIT) begin
                        starve_cnt_d = starve_cnt_q + 3'd1;
                    end
                end else if (!rd_pend) begin
                    starve_cnt_d = '0;
                end
`endif
            end
            ST_RD_ISSUE: begin
                // Memory sees the address this cycle; data returns next.
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                state_d = ST_IDLE;
                if (rd_snd_q) begin
                    snd_rdata_d = mem_q;
                    snd_ack_d   = 1'b1;
                end else begin
                    cpu_rdata_d = mem_q;
                    cpu_ack_d   = 1'b1;
                end
            end
            ST_WR_ISSUE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            buf_full_q  <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            overflow_q  <= 1'b0;
            last_snd_q  <= 1'b1;   // cpu wins the first tie
            rd_snd_q    <= 1'b0;
            cpu_ack_q   <= 1'b0;
            snd_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            snd_rdata_q <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_d_q     <= '0;
`ifdef MEM_ARB_STARVE_GUARD_EN
            starve_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            buf_full_q  <= buf_full_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            overflow_q  <= overflow_d;
            last_snd_q  <= last_snd_d;
            rd_snd_q    <= rd_snd_d;
            cpu_ack_q   <= cpu_ack_d;
            snd_ack_q   <= snd_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            snd_rdata_q <= snd_rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_d_q     <= mem_d_d;
`ifdef MEM_ARB_STARVE_GUARD_EN
            starve_cnt_q <= starve_cnt_d;
`endif
        end
    end

    assign dl_wait     = buf_full_q;
    assign dl_overflow = overflow_q;
    assign cpu_ack     = cpu_ack_q;
    assign snd_ack     = snd_ack_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign snd_rdata   = snd_rdata_q;
    assign mem_addr    = mem_addr_q;
    assign mem_we      = mem_we_q;
    assign mem_d       = mem_d_q;
    assign dbg_state   = state_q;

endmodule
